mem_arbiter: RTL
================

# mem_arbiter

Arbitrates a single shared memory port between the CPU's instruction-fetch path and its load/store path. Fetch uses the program counter output as its address. The load/store path is driven by the control unit's memory-write and result-source decode. The block holds at most one outstanding transaction and latches request fields. It prioritises data accesses, with a bounded-starvation guarantee for fetch, and aborts stuck transactions with a watchdog. It sits between the CPU core and the unified memory.

## Interface
- WIDTH, 32, data and address width
- LS_MAX, 4, maximum consecutive load/store grants while fetch is pending
- TIMEOUT, 16, cycles to wait for mem_ack before abort; 0 disables the watchdog

Ports:
- clk  input  1  CPU clock
- rst  input  1  reset, synchronous, active-low
- if_req  input  1  fetch request
- if_addr  input  WIDTH  fetch address
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  fetch completion pulse
- if_rdata  output  WIDTH  fetched instruction
- ls_req  input  1  load/store request
- ls_we  input  1  1 = store
- ls_addr  input  WIDTH  data address
- ls_wdata  input  WIDTH  store data
- ls_be  input  4  byte enables
- ls_gnt  output  1  load/store accepted this cycle
- ls_rvalid  output  1  load/store completion pulse (stores included)
- ls_rdata  output  WIDTH  load data
- err  output  1  qualifies the rvalid pulse: transaction timed out
- mem_req  output  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  output  1/WIDTH/WIDTH/4  latched request fields
- mem_ack  input  1  memory completion, single-cycle
- mem_rdata  input  WIDTH  valid when mem_ack = 1
- busy  output  1  state != IDLE

## Operation
- States: IDLE, BUSY_IF, BUSY_LS.
- **IDLE arbitration** (combinational gnt, same cycle as acceptance):
  - ls_req and not starve: grant LS.
  - Otherwise if_req: grant IF.
  - Otherwise: no grant.
- **starve** = (ls_cnt == LS_MAX) and if_req.
- **ls_cnt** (width clog2(LS_MAX+1)):
  - +1 on each LS grant while if_req = 1.
  - Clears to 0 on any IF grant, or on any cycle where if_req = 0.
  - Saturates at LS_MAX.
- **On grant:**
  - Latch addr, we, wdata and be into the mem_* registers.
  - An IF grant forces we = 0 and be = 4'hF.
  - Move to BUSY_IF or BUSY_LS.
- **BUSY_x:**
  - mem_req = 1, and request fields are held stable.
  - A wait counter increments each cycle that mem_ack = 0.
  - On mem_ack: capture mem_rdata into x_rdata, pulse x_rvalid next cycle with err = 0, return to IDLE.
- **Watchdog:** if TIMEOUT != 0 and the wait counter reaches TIMEOUT−1 without an ack:
  - Drop mem_req.
  - Pulse x_rvalid with err = 1 and x_rdata = 0.
  - Return to IDLE.
- **Late ack:** a mem_ack arriving in IDLE is ignored.
- **Held data:** if_rdata and ls_rdata hold their value until the next completion of the same requester.
- Requesters must keep req high until gnt. Fields are sampled only in the gnt cycle. Changes after gnt have no effect.

## Timing
- **Reset** (rst = 0 at clock edge):
  - State = IDLE; ls_cnt and the wait counter = 0.
  - mem_req, mem_we, if_rvalid, ls_rvalid, err, busy = 0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0; mem_be = 0.
  - gnt outputs are 0 while rst = 0.
- **Reset mid-transaction:** the transaction is abandoned, no rvalid pulse is produced, and mem_req is low from the next cycle.
- **Minimum transaction** (grant in cycle N, mem_req registered from N+1):
  - mem_ack at N+1; rvalid at N+2.
  - A new grant is possible at N+2, in the same cycle as the previous rvalid.
- **Watchdog abort:** with no ack, rvalid/err pulse at cycle N+1+TIMEOUT; mem_req is high for exactly TIMEOUT cycles.
- **Simultaneous requests in IDLE:** LS wins unless starve.
- Only one gnt is high per cycle, and gnt is never high when state != IDLE.

## Test plan
- **Single fetch:** reset, then if_req = 1, if_addr = 0x40, mem_ack one cycle after mem_req with mem_rdata = 0x00500093. Expect if_gnt at N, mem_addr = 0x40 and mem_we = 0 at N+1, if_rvalid = 1 with if_rdata = 0x00500093 at N+2, err = 0.
- **Store with wait states:** ls_req = 1, ls_we = 1, ls_addr = 0x100, ls_wdata = 0xDEADBEEF, ls_be = 4'b0011, ack after 3 cycles. Expect mem_* held stable for all 3 cycles, one ls_rvalid pulse, busy high throughout.
- **Priority and starvation:** if_req and ls_req held high continuously, ack immediate. Expect grant sequence LS, LS, LS, LS, IF, LS, … (LS_MAX = 4), and never two gnts in one cycle.
- **Watchdog:** TIMEOUT = 16, ls_req load, mem_ack held low. Expect mem_req high for 16 cycles, then ls_rvalid = 1, err = 1, ls_rdata = 0. A later stray mem_ack in IDLE causes no rvalid.
- **Reset mid-operation:** assert rst = 0 during BUSY_IF with ack pending. Expect all outputs at reset values next cycle and no if_rvalid. After rst = 1, a fresh fetch completes normally.
- **Back-to-back:** a fetch rvalid followed by a load granted in the same cycle. Expect the load's mem_req the next cycle and no lost or duplicated completions.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared memory port arbiter: instruction fetch vs load/store,
// data priority with bounded fetch starvation and an ack watchdog.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LS_MAX  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  input  logic [3:0]       ls_be,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam int CW = (LS_MAX < 1) ? 1 : $clog2(LS_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } state_t;

  state_t          state;
  logic [CW-1:0]   ls_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            idle;
  logic            starve;
  logic            ls_max;
  logic            timeout_hit;

  assign idle   = (state == IDLE);
  assign busy   = !idle;
  assign ls_max = (ls_cnt == CW'(LS_MAX));
  assign starve = ls_max && if_req;
  assign ls_gnt = rst && idle && ls_req && !starve;
  assign if_gnt = rst && idle && if_req && !ls_gnt;

  assign timeout_hit = (TIMEOUT != 0) && !mem_ack &&
                       (wait_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ls_cnt    <= '0;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      err       <= 1'b0;

      if (!if_req || if_gnt)
        ls_cnt <= '0;
      else if (ls_gnt && !ls_max)
        ls_cnt <= ls_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          unique case (1'b1)
            ls_gnt: begin
              state     <= BUSY_LS;
              mem_req   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              mem_be    <= ls_be;
              wait_cnt  <= '0;
            end
            if_gnt: begin
              state     <= BUSY_IF;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= 4'hF;
              wait_cnt  <= '0;
            end
            default: ;
          endcase
        end
        BUSY_IF, BUSY_LS: begin
          if (mem_ack || timeout_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            err     <= !mem_ack;
            if (state == BUSY_IF) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_ack ? mem_rdata : '0;
            end else begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
